rst_ckpt: RTL

//  Register Status Table with multi-CDB clear ports and branch checkpoints. Maps each

---
 rtl/rst_ckpt.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rst_ckpt.sv
// Register status table: maps each architectural register to its in-flight producer tag,
// clears completed tags from N_CDB broadcast ports, and keeps an in-order ring of branch snapshots.
module rst_ckpt #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6,
  parameter int N_CDB  = 2,
  parameter int N_CKPT = 4,
  localparam int N_ENTRY = 1 << W_ADDR,
  localparam int W_CK    = $clog2(N_CKPT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [W_ADDR-1:0]        dispatch_rsaddr,
  input  logic [W_ADDR-1:0]        dispatch_rtaddr,
  output logic [W_TAG-1:0]         dispatch_rstag,
  output logic [W_TAG-1:0]         dispatch_rttag,
  output logic                     dispatch_rsvalid,
  output logic                     dispatch_rtvalid,
  input  logic [W_ADDR-1:0]        dispatch_addr,
  input  logic [W_TAG-1:0]         dispatch_tag,
  input  logic                     dispatch_valid,
  input  logic [N_CDB*W_TAG-1:0]   cdb_tag,
  input  logic [N_CDB-1:0]         cdb_valid,
  output logic [N_CDB*N_ENTRY-1:0] regfile_wen,
  input  logic                     ckpt_alloc,
  output logic [W_CK-1:0]          ckpt_id,
  output logic                     ckpt_full,
  input  logic                     ckpt_free,
  input  logic                     ckpt_restore,
  input  logic [W_CK-1:0]          ckpt_restore_id
);

  localparam logic [W_CK:0] CNT_FULL = (W_CK+1)'(N_CKPT);
  localparam logic [W_CK:0] CNT_ONE  = (W_CK+1)'(1);

  logic [N_ENTRY-1:0] tv, tv_n;
  logic [W_TAG-1:0]   tt [N_ENTRY];
  logic [W_TAG-1:0]   tt_n [N_ENTRY];
  logic [N_ENTRY-1:0] sv [N_CKPT];
  logic [N_ENTRY-1:0] sv_n [N_CKPT];
  logic [W_TAG-1:0]   st [N_CKPT][N_ENTRY];
  logic [W_TAG-1:0]   st_n [N_CKPT][N_ENTRY];

  logic [W_CK-1:0] head, head_n, tail, tail_n, rel;
  logic [W_CK:0]   count, count_n;
  logic            do_free, do_rst, do_alloc, hit;

  function automatic logic cdb_hit(input logic [W_TAG-1:0] tag,
                                   input logic [N_CDB-1:0] v,
                                   input logic [N_CDB*W_TAG-1:0] tags);
    logic h;
    h = 1'b0;
    for (int p = 0; p < N_CDB; p++)
      if (v[p] && tags[p*W_TAG +: W_TAG] == tag) h = 1'b1;
    return h;
  endfunction

  assign dispatch_rstag   = tt[dispatch_rsaddr];
  assign dispatch_rttag   = tt[dispatch_rtaddr];
  assign dispatch_rsvalid = tv[dispatch_rsaddr] & ~cdb_hit(tt[dispatch_rsaddr], cdb_valid, cdb_tag);
  assign dispatch_rtvalid = tv[dispatch_rtaddr] & ~cdb_hit(tt[dispatch_rtaddr], cdb_valid, cdb_tag);

  for (genvar p = 0; p < N_CDB; p++) begin : g_port
    for (genvar i = 0; i < N_ENTRY; i++) begin : g_ent
      assign regfile_wen[p*N_ENTRY+i] = cdb_valid[p] & tv[i] & (tt[i] == cdb_tag[p*W_TAG +: W_TAG]);
    end
  end

  assign ckpt_id   = tail;
  assign ckpt_full = (count == CNT_FULL);

  // Liveness is judged against the pre-free head so a restore of the oldest slot still counts.
  always_comb begin
    rel      = ckpt_restore_id - head;
    do_free  = ckpt_free && (count != '0);
    do_rst   = ckpt_restore && ({1'b0, rel} < count);
    do_alloc = ckpt_alloc && !do_rst && (count != CNT_FULL);
    head_n   = head;
    tail_n   = tail;
    count_n  = count;
    if (do_rst) begin
      tail_n = ckpt_restore_id;
      if (ckpt_restore_id == head) begin
        count_n = '0;
      end else begin
        if (do_free) head_n = head + 1'b1;
        count_n = {1'b0, ckpt_restore_id - head_n};
      end
    end else begin
      if (do_free) head_n = head + 1'b1;
      if (do_alloc) tail_n = tail + 1'b1;
      if (do_alloc && !do_free)      count_n = count + CNT_ONE;
      else if (!do_alloc && do_free) count_n = count - CNT_ONE;
    end
  end

  always_comb begin
    for (int s = 0; s < N_CKPT; s++) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        hit = sv[s][i] & cdb_hit(st[s][i], cdb_valid, cdb_tag);
        sv_n[s][i] = sv[s][i] & ~hit;
        st_n[s][i] = hit ? '0 : st[s][i];
      end
    end
    for (int i = 0; i < N_ENTRY; i++) begin
      hit = tv[i] & cdb_hit(tt[i], cdb_valid, cdb_tag);
      tv_n[i] = tv[i] & ~hit;
      tt_n[i] = hit ? '0 : tt[i];
    end
    if (do_rst) begin
      tv_n = sv_n[ckpt_restore_id];
      tt_n = st_n[ckpt_restore_id];
    end else if (dispatch_valid) begin
      tv_n[dispatch_addr] = 1'b1;
      tt_n[dispatch_addr] = dispatch_tag;
    end
    if (do_alloc) begin
      sv_n[tail] = tv_n;
      st_n[tail] = tt_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tv    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < N_ENTRY; i++) tt[i] <= '0;
      for (int s = 0; s < N_CKPT; s++) begin
        sv[s] <= '0;
        for (int i = 0; i < N_ENTRY; i++) st[s][i] <= '0;
      end
    end else begin
      tv    <= tv_n;
      tt    <= tt_n;
      sv    <= sv_n;
      st    <= st_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

endmodule
